// File: rtl/integer_execute_pkg.sv
// Shared funct3/funct7 encodings for the RV32I execute stage.
package integer_execute_pkg;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_MUL     = 3'b000;
  localparam logic [2:0] F3_MULH    = 3'b001;
  localparam logic [2:0] F3_MULHSU  = 3'b010;
  localparam logic [2:0] F3_MULHU   = 3'b011;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

endpackage

// File: rtl/integer_alu_core.sv
// Combinational RV32I ALU shared by the R-type and I-type paths.
module integer_alu_core
  import integer_execute_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  input  logic [2:0]      i_funct3,
  input  logic            i_alt,
  input  logic            i_unsigned_cmp,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] w_shamt;
  logic           w_lt;

  assign w_shamt = i_operand_b[SHW-1:0];
  assign w_lt    = i_unsigned_cmp ? (i_operand_a < i_operand_b)
                                  : ($signed(i_operand_a) < $signed(i_operand_b));

  always_comb begin
    o_result = '0;
    case (i_funct3)
      F3_ADD_SUB: o_result = i_alt ? (i_operand_a - i_operand_b) : (i_operand_a + i_operand_b);
      F3_SLL:     o_result = i_operand_a << w_shamt;
      F3_SLT,
      F3_SLTU:    o_result = {{(XLEN-1){1'b0}}, w_lt};
      F3_XOR:     o_result = i_operand_a ^ i_operand_b;
      F3_SRL_SRA: o_result = i_alt ? $unsigned($signed(i_operand_a) >>> w_shamt)
                                   : (i_operand_a >> w_shamt);
      F3_OR:      o_result = i_operand_a | i_operand_b;
      F3_AND:     o_result = i_operand_a & i_operand_b;
      default:    o_result = '0;
    endcase
  end

endmodule

// File: rtl/integer_execute_unit.sv
// RV32I execute stage: registered R-type, I-type and AUIPC results with error flags.
// Define INTEGER_EXECUTE_MULTIPLY_EN to accept the M-extension multiplies (funct7=0000001).
module integer_execute_unit
  import integer_execute_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [2:0]      subfunction_3,
  input  logic [6:0]      subfunction_7,
  input  logic [XLEN-1:0] input_register1_value,
  input  logic [XLEN-1:0] input_register2_value,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] program_counter,
  output logic [XLEN-1:0] rtype_result,
  output logic [XLEN-1:0] itype_result,
  output logic [XLEN-1:0] auipc_result,
  output logic            rtype_error,
  output logic            itype_error,
  output logic            auipc_error
);

  logic [XLEN-1:0] w_r_alu, w_i_alu, w_r_result, w_i_result, w_auipc, w_mul_result;
  logic            w_r_alt, w_r_unsigned, w_r_base, w_r_alt_ok, w_r_error, w_mul_sel;
  logic [6:0]      w_i_f7;
  logic            w_i_alt, w_i_unsigned, w_i_error;
  logic [XLEN-1:0] r_rtype_result, r_itype_result, r_auipc_result;
  logic            r_rtype_error, r_itype_error;

  assign w_r_alt      = (subfunction_7 == F7_ALT);
  assign w_r_unsigned = (subfunction_3 == F3_SLTU);
  assign w_r_base     = (subfunction_7 == F7_BASE);
  assign w_r_alt_ok   = w_r_alt && ((subfunction_3 == F3_ADD_SUB) || (subfunction_3 == F3_SRL_SRA));

  integer_alu_core #(.XLEN(XLEN)) u_r_alu (
    .i_operand_a   (input_register1_value),
    .i_operand_b   (input_register2_value),
    .i_funct3      (subfunction_3),
    .i_alt         (w_r_alt),
    .i_unsigned_cmp(w_r_unsigned),
    .o_result      (w_r_alu)
  );

`ifdef INTEGER_EXECUTE_MULTIPLY_EN
  logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_mul_prod;
  logic              w_mul_a_signed, w_mul_b_signed;

  // Sign-extend to 2*XLEN so one truncated product covers all four variants.
  assign w_mul_sel      = (subfunction_7 == F7_MULDIV) && !subfunction_3[2];
  assign w_mul_a_signed = (subfunction_3 == F3_MULH) || (subfunction_3 == F3_MULHSU);
  assign w_mul_b_signed = (subfunction_3 == F3_MULH);
  assign w_mul_a        = {{XLEN{w_mul_a_signed & input_register1_value[XLEN-1]}}, input_register1_value};
  assign w_mul_b        = {{XLEN{w_mul_b_signed & input_register2_value[XLEN-1]}}, input_register2_value};
  assign w_mul_prod     = w_mul_a * w_mul_b;
  assign w_mul_result   = (subfunction_3 == F3_MUL) ? w_mul_prod[XLEN-1:0] : w_mul_prod[2*XLEN-1:XLEN];
`else
  assign w_mul_sel    = 1'b0;
  assign w_mul_result = '0;
`endif

  assign w_r_error  = !(w_r_base || w_r_alt_ok || w_mul_sel);
  assign w_r_result = w_r_error ? '0 : (w_mul_sel ? w_mul_result : w_r_alu);

  // The alt bit only means SRAI for funct3=101; ADDI with imm[10] set must still add.
  assign w_i_f7       = immediate[11:5];
  assign w_i_alt      = (subfunction_3 == F3_SRL_SRA) && (w_i_f7 == F7_ALT);
  assign w_i_unsigned = (subfunction_3 == F3_SLTU);
  assign w_i_error    = ((subfunction_3 == F3_SLL) && (w_i_f7 != F7_BASE)) ||
                        ((subfunction_3 == F3_SRL_SRA) && (w_i_f7 != F7_BASE) && (w_i_f7 != F7_ALT));

  integer_alu_core #(.XLEN(XLEN)) u_i_alu (
    .i_operand_a   (input_register1_value),
    .i_operand_b   (immediate),
    .i_funct3      (subfunction_3),
    .i_alt         (w_i_alt),
    .i_unsigned_cmp(w_i_unsigned),
    .o_result      (w_i_alu)
  );

  assign w_i_result = w_i_error ? '0 : w_i_alu;
  assign w_auipc    = program_counter + immediate;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rtype_result <= '0;
      r_itype_result <= '0;
      r_auipc_result <= '0;
      r_rtype_error  <= 1'b0;
      r_itype_error  <= 1'b0;
    end else if (enable) begin
      r_rtype_result <= w_r_result;
      r_itype_result <= w_i_result;
      r_auipc_result <= w_auipc;
      r_rtype_error  <= w_r_error;
      r_itype_error  <= w_i_error;
    end
  end

  assign rtype_result = r_rtype_result;
  assign itype_result = r_itype_result;
  assign auipc_result = r_auipc_result;
  assign rtype_error  = r_rtype_error;
  assign itype_error  = r_itype_error;
  assign auipc_error  = 1'b0;

endmodule

// File: tb/tb_integer_execute_unit.sv
// Scoreboard bench for integer_execute_unit; honours INTEGER_EXECUTE_MULTIPLY_EN when defined.
module tb_integer_execute_unit;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] i;
    logic [31:0] a;
    logic        re;
    logic        ie;
    logic        ae;
  } out_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  f3 = '0;
  logic [6:0]  f7 = '0;
  logic [31:0] rs1 = '0, rs2 = '0, imm = '0, pc = '0;
  logic [31:0] rtype_result, itype_result, auipc_result;
  logic        rtype_error, itype_error, auipc_error;

  int unsigned errors = 0;
  int unsigned checks = 0;
  out_t        sb[$];
  out_t        exp_o, got_o, held_o;

  integer_execute_unit #(.XLEN(32)) dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .subfunction_3        (f3),
    .subfunction_7        (f7),
    .input_register1_value(rs1),
    .input_register2_value(rs2),
    .immediate            (imm),
    .program_counter      (pc),
    .rtype_result         (rtype_result),
    .itype_result         (itype_result),
    .auipc_result         (auipc_result),
    .rtype_error          (rtype_error),
    .itype_error          (itype_error),
    .auipc_error          (auipc_error)
  );

  always #5 clk = ~clk;

  function automatic out_t observed();
    return {rtype_result, itype_result, auipc_result, rtype_error, itype_error, auipc_error};
  endfunction

  function automatic out_t model(input logic [2:0] m3, input logic [6:0] m7,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] im, input logic [31:0] p);
    out_t o;
    logic [4:0] sh;
    logic [6:0] hi;
    longint sa, sb_;
    longint unsigned ua, ub, up;
    longint sp;
    o = '0;
    o.a = p + im;
    sh = b[4:0];
    case (m7)
      7'h00:
        case (m3)
          3'd0: o.r = a + b;
          3'd1: o.r = a << sh;
          3'd2: o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: o.r = (a < b) ? 32'd1 : 32'd0;
          3'd4: o.r = a ^ b;
          3'd5: o.r = a >> sh;
          3'd6: o.r = a | b;
          default: o.r = a & b;
        endcase
      7'h20:
        if (m3 == 3'd0) o.r = a - b;
        else if (m3 == 3'd5) o.r = $signed(a) >>> sh;
        else o.re = 1'b1;
`ifdef INTEGER_EXECUTE_MULTIPLY_EN
      7'h01: begin
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (m3)
          3'd0: o.r = a * b;
          3'd1: begin sp = sa * sb_; o.r = sp[63:32]; end
          3'd2: begin sp = sa * longint'(ub); o.r = sp[63:32]; end
          3'd3: begin up = ua * ub; o.r = up[63:32]; end
          default: o.re = 1'b1;
        endcase
      end
`endif
      default: o.re = 1'b1;
    endcase
    hi = im[11:5];
    sh = im[4:0];
    case (m3)
      3'd0: o.i = a + im;
      3'd1: if (hi == 7'h00) o.i = a << sh; else o.ie = 1'b1;
      3'd2: o.i = ($signed(a) < $signed(im)) ? 32'd1 : 32'd0;
      3'd3: o.i = (a < im) ? 32'd1 : 32'd0;
      3'd4: o.i = a ^ im;
      3'd5:
        if (hi == 7'h00) o.i = a >> sh;
        else if (hi == 7'h20) o.i = $signed(a) >>> sh;
        else o.ie = 1'b1;
      3'd6: o.i = a | im;
      default: o.i = a & im;
    endcase
    return o;
  endfunction

  task automatic issue(input logic [2:0] t3, input logic [6:0] t7, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic [31:0] p);
    f3 = t3; f7 = t7; rs1 = a; rs2 = b; imm = im; pc = p; enable = 1'b1;
    sb.push_back(model(t3, t7, a, b, im, p));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    f3 = 3'd0; f7 = 7'h00; rs1 = 32'h11; rs2 = 32'h22; imm = 32'h33; pc = 32'h44; enable = 1'b1;
    #1;
    checks++;
    if (observed() !== out_t'('0)) begin
      errors++; $display("FAIL reset_initial: got %h expected 0", observed());
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (observed() !== out_t'('0)) begin
      errors++; $display("FAIL reset_held_with_clock: got %h expected 0", observed());
    end
    reset = 1'b0;
  endtask

  task automatic test_auipc();
    issue(3'd0, 7'h00, 32'h0, 32'h0, 32'h12345000, 32'h00001000);
    exp_o = sb.pop_front(); got_o = observed();
    checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL auipc_sb: got %h expected %h", got_o, exp_o); end
    checks++;
    if (auipc_result !== 32'h12346000) begin errors++; $display("FAIL auipc_value: got %h expected 12346000", auipc_result); end
    checks++;
    if (auipc_error !== 1'b0) begin errors++; $display("FAIL auipc_error: got %b expected 0", auipc_error); end
  endtask

  task automatic test_add_sub();
    issue(3'd0, 7'h00, 32'd3, 32'd5, 32'hFFFFFFFF, 32'h0);
    exp_o = sb.pop_front(); got_o = observed();
    checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL add_sb: got %h expected %h", got_o, exp_o); end
    checks++;
    if (rtype_result !== 32'h8) begin errors++; $display("FAIL add: got %h expected 00000008", rtype_result); end
    issue(3'd0, 7'h20, 32'd3, 32'd5, 32'h0, 32'h0);
    exp_o = sb.pop_front(); got_o = observed();
    checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL sub_sb: got %h expected %h", got_o, exp_o); end
    checks++;
    if (rtype_result !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub: got %h expected fffffffe", rtype_result); end
  endtask

  task automatic test_addi();
    issue(3'd0, 7'h00, 32'd5, 32'd0, 32'hFFFFFFFF, 32'h0);
    exp_o = sb.pop_front(); got_o = observed();
    checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL addi_sb: got %h expected %h", got_o, exp_o); end
    checks++;
    if (itype_result !== 32'h4) begin errors++; $display("FAIL addi: got %h expected 00000004", itype_result); end
  endtask

  task automatic test_shifts();
    logic [31:0] want_r [3] = '{32'h08000000, 32'hF8000000, 32'h00000000};
    logic [2:0]  t3     [3] = '{3'd5, 3'd5, 3'd1};
    logic [6:0]  t7     [3] = '{7'h00, 7'h20, 7'h00};
    logic [31:0] tim    [3] = '{32'h004, 32'h404, 32'h004};
    for (int k = 0; k < 3; k++) begin
      issue(t3[k], t7[k], 32'h80000000, 32'd4, tim[k], 32'h0);
      exp_o = sb.pop_front(); got_o = observed();
      checks++;
      if (got_o !== exp_o) begin errors++; $display("FAIL shift_sb[%0d]: got %h expected %h", k, got_o, exp_o); end
      checks++;
      if (rtype_result !== want_r[k] || itype_result !== want_r[k])
        begin errors++; $display("FAIL shift[%0d]: got r=%h i=%h expected %h", k, rtype_result, itype_result, want_r[k]); end
    end
    issue(3'd5, 7'h00, 32'h1234ABCD, 32'd0, 32'h0, 32'h0);
    exp_o = sb.pop_front(); got_o = observed();
    checks++;
    if (rtype_result !== 32'h1234ABCD || itype_result !== 32'h1234ABCD || got_o !== exp_o)
      begin errors++; $display("FAIL shift_zero: got r=%h i=%h expected 1234abcd", rtype_result, itype_result); end
  endtask

  task automatic test_compares();
    issue(3'd2, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd1, 32'h0);
    exp_o = sb.pop_front(); got_o = observed();
    checks++;
    if (got_o !== exp_o || rtype_result !== 32'd1) begin errors++; $display("FAIL slt: got %h expected r=00000001", got_o); end
    issue(3'd3, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd1, 32'h0);
    exp_o = sb.pop_front(); got_o = observed();
    checks++;
    if (got_o !== exp_o || rtype_result !== 32'd0) begin errors++; $display("FAIL sltu: got %h expected r=00000000", got_o); end
    issue(3'd3, 7'h00, 32'd5, 32'd0, 32'hFFFFFFFF, 32'h0);
    exp_o = sb.pop_front(); got_o = observed();
    checks++;
    if (got_o !== exp_o || itype_result !== 32'd1) begin errors++; $display("FAIL sltiu: got %h expected i=00000001", got_o); end
  endtask

  task automatic test_errors();
    issue(3'd0, 7'h01, 32'd7, 32'd9, 32'h0, 32'h0);
    exp_o = sb.pop_front(); got_o = observed();
    checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL f7_muldiv_sb: got %h expected %h", got_o, exp_o); end
`ifndef INTEGER_EXECUTE_MULTIPLY_EN
    checks++;
    if (rtype_error !== 1'b1 || rtype_result !== 32'h0)
      begin errors++; $display("FAIL f7_muldiv_err: got err=%b r=%h expected err=1 r=0", rtype_error, rtype_result); end
`else
    checks++;
    if (rtype_error !== 1'b0 || rtype_result !== 32'd63)
      begin errors++; $display("FAIL mul: got err=%b r=%h expected err=0 r=3f", rtype_error, rtype_result); end
`endif
    issue(3'd1, 7'h20, 32'h5, 32'h1, 32'h404, 32'h0);
    exp_o = sb.pop_front(); got_o = observed();
    checks++;
    if (got_o !== exp_o) begin errors++; $display("FAIL slli_bad_sb: got %h expected %h", got_o, exp_o); end
    checks++;
    if (itype_error !== 1'b1 || itype_result !== 32'h0 || rtype_error !== 1'b1)
      begin errors++; $display("FAIL slli_bad: got ie=%b i=%h re=%b expected ie=1 i=0 re=1", itype_error, itype_result, rtype_error); end
  endtask

  task automatic test_enable_hold();
    issue(3'd4, 7'h00, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h00000123, 32'h00400000);
    held_o = sb.pop_front();
    enable = 1'b0;
    f3 = 3'd0; f7 = 7'h7F; rs1 = 32'h1; rs2 = 32'h2; imm = 32'hFFF; pc = 32'h8;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (observed() !== held_o) begin errors++; $display("FAIL enable_hold: got %h expected %h", observed(), held_o); end
  endtask

  task automatic test_async_reset();
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (observed() !== out_t'('0)) begin errors++; $display("FAIL async_reset: got %h expected 0", observed()); end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0]  f7_pick [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
    logic [6:0]  hi_pick [4] = '{7'h00, 7'h20, 7'h00, 7'h00};
    logic [2:0]  t3;
    logic [6:0]  t7, hi;
    logic [31:0] a, b, im, p;
    for (int n = 0; n < 40; n++) begin
      t3 = 3'($urandom_range(7, 0));
      t7 = (n % 5 == 4) ? 7'($urandom) : f7_pick[$urandom_range(3, 0)];
      hi = (n % 7 == 6) ? 7'($urandom) : hi_pick[$urandom_range(3, 0)];
      a  = $urandom;
      b  = $urandom;
      im = {{20{hi[6]}}, hi, 5'($urandom)};
      p  = $urandom;
      issue(t3, t7, a, b, im, p);
      exp_o = sb.pop_front(); got_o = observed();
      checks++;
      if (got_o !== exp_o) begin errors++; $display("FAIL b2b[%0d] f3=%0d f7=%h: got %h expected %h", n, t3, t7, got_o, exp_o); end
    end
  endtask

  initial begin
    test_reset();
    test_auipc();
    test_add_sub();
    test_addi();
    test_shifts();
    test_compares();
    test_errors();
    test_enable_hold();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
